// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: default widths,
// the in-flight slot record and the regfile bypass select code.
`timescale 1ns/100ps
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_REG_AW = 5;

  // Select value meaning "read the register file, no forwarding".
  localparam int BYP_REGFILE = 0;

  typedef struct packed {
    logic                   valid;
    logic                   wr;
    logic                   is_load;
    logic [PIPE_REG_AW-1:0] rd;
    logic [PIPE_DATA_W-1:0] insn;
  } slot_t;

endpackage

// File: rtl/pipe_slot_reg.sv
// One in-flight pipeline slot: loads its upstream neighbour every edge, or an
// all-zero bubble when bubble is asserted; cleared asynchronously by reset low.
`timescale 1ns/100ps
module pipe_slot_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic              in_wr,
  input  logic              in_is_load,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [DATA_W-1:0] in_insn,
  output logic              q_valid,
  output logic              q_wr,
  output logic              q_is_load,
  output logic [REG_AW-1:0] q_rd,
  output logic [DATA_W-1:0] q_insn
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_valid   <= 1'b0;
      q_wr      <= 1'b0;
      q_is_load <= 1'b0;
      q_rd      <= '0;
      q_insn    <= '0;
    end else if (bubble) begin
      q_valid   <= 1'b0;
      q_wr      <= 1'b0;
      q_is_load <= 1'b0;
      q_rd      <= '0;
      q_insn    <= '0;
    end else begin
      q_valid   <= in_valid;
      q_wr      <= in_wr;
      q_is_load <= in_is_load;
      q_rd      <= in_rd;
      q_insn    <= in_insn;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Parametrised pipeline control: in-flight slot chain, RAW bypass selects and
// load-use stall with flush override. Optional PIPE_HAZARD_PERF_EN adds counters.
`timescale 1ns/100ps
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int REG_AW = PIPE_REG_AW,
  parameter int STAGES = 3,
  parameter int SEL_W  = $clog2(STAGES+1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     dec_valid,
  output logic                     dec_ready,
  input  logic [DATA_W-1:0]        dec_insn,
  input  logic [REG_AW-1:0]        dec_rs,
  input  logic [REG_AW-1:0]        dec_rt,
  input  logic                     dec_rs_used,
  input  logic                     dec_rt_used,
  input  logic [REG_AW-1:0]        dec_rd,
  input  logic                     dec_wr,
  input  logic                     dec_is_load,
  input  logic                     flush,
  output logic [SEL_W-1:0]         byp_a_sel,
  output logic [SEL_W-1:0]         byp_b_sel,
  output logic [STAGES-1:0]        stg_valid,
  output logic [STAGES*DATA_W-1:0] stg_insn,
  output logic [STAGES*REG_AW-1:0] stg_rd,
  output logic [STAGES-1:0]        stg_wr
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_retire_cnt
`endif
);

  logic [STAGES-1:0] s_load;
  logic [REG_AW-1:0] s_rd [STAGES];
  logic [STAGES-1:0] prod_a;
  logic [STAGES-1:0] prod_b;
  logic              stall;
  logic              slot1_bubble;
  logic              unused_last_load;

  // The oldest slot's load flag has no consumer; it only matters in slot 1.
  assign unused_last_load = s_load[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      logic              bub;
      logic              v;
      logic              w;
      logic              l;
      logic [REG_AW-1:0] r;
      logic [DATA_W-1:0] i;
      logic [DATA_W-1:0] q_insn;

      if (gi == 0) begin : g_head
        assign bub = slot1_bubble;
        assign v   = dec_valid;
        assign w   = dec_wr;
        assign l   = dec_is_load;
        assign r   = dec_rd;
        assign i   = dec_insn;
      end else begin : g_tail
        assign bub = 1'b0;
        assign v   = stg_valid[gi-1];
        assign w   = stg_wr[gi-1];
        assign l   = s_load[gi-1];
        assign r   = s_rd[gi-1];
        assign i   = g_slot[gi-1].q_insn;
      end

      pipe_slot_reg #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
      ) u_slot (
        .clock      (clock),
        .reset      (reset),
        .bubble     (bub),
        .in_valid   (v),
        .in_wr      (w),
        .in_is_load (l),
        .in_rd      (r),
        .in_insn    (i),
        .q_valid    (stg_valid[gi]),
        .q_wr       (stg_wr[gi]),
        .q_is_load  (s_load[gi]),
        .q_rd       (s_rd[gi]),
        .q_insn     (q_insn)
      );

      assign stg_insn[(gi+1)*DATA_W-1 -: DATA_W] = q_insn;
      assign stg_rd[(gi+1)*REG_AW-1 -: REG_AW]   = s_rd[gi];

      // r0 is never a producer, and a bubble has wr=0 so it never matches.
      assign prod_a[gi] = stg_valid[gi] & stg_wr[gi] & (s_rd[gi] == dec_rs)
                          & (dec_rs != '0) & dec_rs_used;
      assign prod_b[gi] = stg_valid[gi] & stg_wr[gi] & (s_rd[gi] == dec_rt)
                          & (dec_rt != '0) & dec_rt_used;
    end
  endgenerate

  // Scan oldest to youngest so the youngest producer overwrites the choice.
  always_comb begin
    byp_a_sel = SEL_W'(BYP_REGFILE);
    byp_b_sel = SEL_W'(BYP_REGFILE);
    for (int k = STAGES; k >= 1; k--) begin
      if (prod_a[k-1]) byp_a_sel = SEL_W'(k);
      if (prod_b[k-1]) byp_b_sel = SEL_W'(k);
    end
  end

  assign stall        = dec_valid & ~flush & s_load[0] & (prod_a[0] | prod_b[0]);
  assign dec_ready    = ~stall;
  assign slot1_bubble = flush | stall | ~dec_valid;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt  <= '0;
      perf_retire_cnt <= '0;
    end else begin
      if (stall)               perf_stall_cnt  <= perf_stall_cnt + 32'd1;
      if (stg_valid[STAGES-1]) perf_retire_cnt <= perf_retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (STAGES=3): bypass, load-use stall,
// priority, flush and reset; perf counters when PIPE_HAZARD_PERF_EN is defined.
`timescale 1ns/100ps
module tb_pipe_hazard_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int ST = 3;
  localparam int SW = 2;

  logic            clock;
  logic            reset;
  logic            dec_valid;
  logic            dec_ready;
  logic [DW-1:0]   dec_insn;
  logic [AW-1:0]   dec_rs;
  logic [AW-1:0]   dec_rt;
  logic            dec_rs_used;
  logic            dec_rt_used;
  logic [AW-1:0]   dec_rd;
  logic            dec_wr;
  logic            dec_is_load;
  logic            flush;
  logic [SW-1:0]   byp_a_sel;
  logic [SW-1:0]   byp_b_sel;
  logic [ST-1:0]   stg_valid;
  logic [ST*DW-1:0] stg_insn;
  logic [ST*AW-1:0] stg_rd;
  logic [ST-1:0]   stg_wr;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]     perf_stall_cnt;
  logic [31:0]     perf_retire_cnt;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  pipe_hazard_ctrl #(.DATA_W(DW), .REG_AW(AW), .STAGES(ST)) dut (
    .clock       (clock),
    .reset       (reset),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_insn    (dec_insn),
    .dec_rs      (dec_rs),
    .dec_rt      (dec_rt),
    .dec_rs_used (dec_rs_used),
    .dec_rt_used (dec_rt_used),
    .dec_rd      (dec_rd),
    .dec_wr      (dec_wr),
    .dec_is_load (dec_is_load),
    .flush       (flush),
    .byp_a_sel   (byp_a_sel),
    .byp_b_sel   (byp_b_sel),
    .stg_valid   (stg_valid),
    .stg_insn    (stg_insn),
    .stg_rd      (stg_rd),
    .stg_wr      (stg_wr)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_retire_cnt (perf_retire_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-14s got %0h exp %0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-14s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic ru, input logic tu, input logic [AW-1:0] rd,
                       input logic wr, input logic ld, input logic [DW-1:0] insn);
    dec_valid   = v;
    dec_rs      = rs;
    dec_rt      = rt;
    dec_rs_used = ru;
    dec_rt_used = tu;
    dec_rd      = rd;
    dec_wr      = wr;
    dec_is_load = ld;
    dec_insn    = insn;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drain;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    flush = 1'b0;
    repeat (ST) tick();
  endtask

  function automatic logic [AW-1:0] slot_rd(input int k);
    return stg_rd[k*AW-1 -: AW];
  endfunction

  function automatic logic [DW-1:0] slot_insn(input int k);
    return stg_insn[k*DW-1 -: DW];
  endfunction

`ifdef PIPE_HAZARD_PERF_EN
  task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rd,
                       input logic ld, input logic [DW-1:0] insn);
    drive(1, rs, 0, 1, 1, rd, 1, ld, insn);
    #1;
    for (int n = 0; n < 4 && !dec_ready; n++) tick();
    if (!dec_ready) check("issue_timeout", 64'(dec_ready), 64'(1));
    tick();
  endtask
`endif

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_valid", 64'(stg_valid), 64'(0));
    check("rst_wr",    64'(stg_wr),    64'(0));
    check("rst_ready", 64'(dec_ready), 64'(1));
    check("rst_a_sel", 64'(byp_a_sel), 64'(0));
    @(posedge clock);
    #1 reset = 1'b1;
    tick();

    // Back-to-back ALU dependency
    drive(1, 1, 2, 1, 1, 3, 1, 0, 32'h11);
    #1;
    check("alu1_ready", 64'(dec_ready), 64'(1));
    check("alu1_a_sel", 64'(byp_a_sel), 64'(0));
    tick();
    check("alu1_valid", 64'(stg_valid), 64'(3'b001));
    check("alu1_rd",    64'(slot_rd(1)), 64'(3));
    drive(1, 3, 3, 1, 1, 4, 1, 0, 32'h22);
    #1;
    check("alu2_a_sel", 64'(byp_a_sel), 64'(1));
    check("alu2_b_sel", 64'(byp_b_sel), 64'(1));
    check("alu2_ready", 64'(dec_ready), 64'(1));
    tick();
    drive(1, 3, 0, 1, 0, 8, 1, 0, 32'h33);
    #1;
    check("alu3_a_sel", 64'(byp_a_sel), 64'(2));
    check("alu3_b_sel", 64'(byp_b_sel), 64'(0));
    tick();
    check("alu3_valid", 64'(stg_valid), 64'(3'b111));
    check("alu3_wr",    64'(stg_wr),    64'(3'b111));
    check("alu3_insn3", 64'(slot_insn(3)), 64'(32'h11));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("drain_valid", 64'(stg_valid), 64'(3'b110));
    check("bubble_insn", 64'(slot_insn(1)), 64'(0));
    drain();
    check("empty_valid", 64'(stg_valid), 64'(0));

    // Load-use stall
    drive(1, 1, 0, 1, 0, 5, 1, 1, 32'h44);
    #1;
    check("lw_ready", 64'(dec_ready), 64'(1));
    tick();
    drive(1, 5, 0, 1, 1, 6, 1, 0, 32'h55);
    #1;
    check("lu_ready", 64'(dec_ready), 64'(0));
    check("lu_a_sel", 64'(byp_a_sel), 64'(1));
    tick();
    check("lu_bubble",  64'(stg_valid), 64'(3'b010));
    check("lu2_ready",  64'(dec_ready), 64'(1));
    check("lu2_a_sel",  64'(byp_a_sel), 64'(2));
    check("lu2_b_sel",  64'(byp_b_sel), 64'(0));
    tick();
    check("lu3_valid", 64'(stg_valid), 64'(3'b101));
    check("lu3_rd",    64'(slot_rd(1)), 64'(6));
    check("lu3_insn",  64'(slot_insn(1)), 64'(32'h55));
    drain();

    // Priority and r0
    drive(1, 0, 0, 0, 0, 7, 1, 0, 32'h71);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 32'h72);
    tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 32'h73);
    tick();
    drive(0, 7, 0, 1, 1, 0, 0, 0, 0);
    #1;
    check("pri_a_sel",  64'(byp_a_sel), 64'(1));
    check("pri_r0_sel", 64'(byp_b_sel), 64'(0));
    tick();
    check("pri2_a_sel", 64'(byp_a_sel), 64'(2));
    tick();
    check("pri3_a_sel", 64'(byp_a_sel), 64'(3));
    tick();
    check("pri4_a_sel", 64'(byp_a_sel), 64'(0));
    drain();

    // Flush during load-use
    drive(1, 1, 0, 1, 0, 5, 1, 1, 32'h66);
    tick();
    drive(0, 5, 0, 1, 0, 6, 1, 0, 32'h67);
    #1;
    check("novalid_ready", 64'(dec_ready), 64'(1));
    dec_valid = 1'b1;
    flush     = 1'b1;
    #1;
    check("flush_ready", 64'(dec_ready), 64'(1));
    check("flush_a_sel", 64'(byp_a_sel), 64'(1));
    tick();
    check("flush_bubble", 64'(stg_valid), 64'(3'b010));
    drain();

    // Reset mid-stream
    drive(1, 0, 0, 0, 0, 1, 1, 0, 32'h81);
    tick();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 32'h82);
    tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 32'h83);
    tick();
    check("full_valid", 64'(stg_valid), 64'(3'b111));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #0.5;
    check("mrst_valid", 64'(stg_valid), 64'(0));
    check("mrst_wr",    64'(stg_wr),    64'(0));
    check("mrst_ready", 64'(dec_ready), 64'(1));
    check("mrst_insn",  64'(stg_insn[63:0]), 64'(0));
    #0.5;
    reset = 1'b1;
    tick();
    check("post_valid", 64'(stg_valid), 64'(0));
    check("post_wr",    64'(stg_wr),    64'(0));

`ifdef PIPE_HAZARD_PERF_EN
    issue(1, 5, 1, 32'h900);
    issue(5, 6, 0, 32'h901);
    issue(1, 3, 0, 32'h902);
    issue(1, 3, 0, 32'h903);
    issue(1, 10, 1, 32'h904);
    issue(10, 11, 0, 32'h905);
    issue(1, 3, 0, 32'h906);
    issue(1, 3, 0, 32'h907);
    issue(1, 3, 0, 32'h908);
    issue(1, 3, 0, 32'h909);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) tick();
    check("perf_stall",  64'(perf_stall_cnt),  64'(2));
    check("perf_retire", 64'(perf_retire_cnt), 64'(10));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline-control successor to the fixed 5-stage latch chain in the core.
- Tracks in-flight instructions after decode across STAGES pipeline slots (slot 1 = execute ... slot STAGES = writeback).
- Detects RAW hazards between decode sources and in-flight destinations. Generates bypass selects, load-use stalls and bubbles, and honours branch flush.
- Sits between the decode latch and the execute/memory/writeback datapath registers of the processor.

Parameters:
- DATA_W, 32, instruction/data word width carried per slot
- REG_AW, 5, register-index width; register 0 is hard-wired zero
- STAGES, 3, number of in-flight slots after decode (min 2)
- SEL_W, $clog2(STAGES+1), width of each bypass select

Ports:
- clock  in  1  master clock, rising-edge
- reset  in  1  asynchronous, active-low; clears all slots
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  slot 1 accepts the decode instruction this cycle
- dec_insn  in  DATA_W  decoded instruction word
- dec_rs, dec_rt  in  REG_AW  source register indices
- dec_rs_used, dec_rt_used  in  1  source actually read
- dec_rd  in  REG_AW  destination register
- dec_wr  in  1  instruction writes dec_rd
- dec_is_load  in  1  result available only at slot 2 or later
- flush  in  1  branch/jump resolved taken in slot 1; kill the decode instruction
- byp_a_sel, byp_b_sel  out  SEL_W  0 = regfile, k = forward from slot k
- stg_valid  out  STAGES  valid bit per slot, bit k-1 = slot k
- stg_insn  out  STAGES*DATA_W  instruction per slot, slot k in bits [k*DATA_W-1 -: DATA_W]
- stg_rd  out  STAGES*REG_AW  destination per slot
- stg_wr  out  STAGES  write-enable per slot; writeback uses slot STAGES

Behaviour:
- Reset (async, reset=0):
  - All stg_valid, stg_wr = 0; stg_insn, stg_rd = 0.
  - byp selects = 0, dec_ready = 1.
  - Release is synchronised to the next rising edge.
- Every rising edge, slots k = 2..STAGES load slot k-1 unconditionally. The pipeline never freezes past slot 1.
- Hazard qualification: a slot k is a producer for source s iff stg_valid[k] & stg_wr[k] & stg_rd[k]==s & s!=0 & s_used.
- Bypass (combinational): the select takes the lowest k (youngest) producer; 0 if none. Slot STAGES is included, so correctness never relies on regfile write-through.
- Load-use stall (combinational): stall = dec_valid & ~flush & (producer in slot 1 with is_load, for either source).
- Slot 1 load:
  - flush=1: bubble (valid 0); dec_ready = 1 so upstream drops the instruction. Flush overrides stall.
  - stall=1: bubble; dec_ready = 0; decode holds its instruction.
  - dec_valid=0: bubble; dec_ready = 1.
  - Otherwise: capture dec_*; valid 1; dec_ready = 1.
- A stalled instruction re-evaluates next cycle. The load is now in slot 2, so it proceeds with byp sel = 2.
- A bubble carries wr=0, rd=0, insn=0. Bubbles are never hazard sources.
- Writes to r0 are never hazards; dec_wr with rd=0 is legal and simply never forwarded.
- Both sources matching different slots are resolved independently.
- Same-cycle flush and load-use: flush wins, no stall.
- Reset mid-operation: all in-flight instructions are discarded immediately; no writeback is asserted afterwards.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt [31:0] and perf_retire_cnt [31:0].
  - perf_stall_cnt increments on every stall cycle; perf_retire_cnt increments whenever slot STAGES is valid.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - REG_AW and DATA_W defaults.
  - Slot record typedef {valid, wr, is_load, rd, insn}.
  - Constant BYP_REGFILE = 0.
- One natural sub-module: pipe_slot_reg, one slot register with async active-low clear and bubble-insert input, instantiated STAGES times.
- Hazard/bypass priority logic stays in the top.

Test Plan:
- Reset mid-stream: fill 3 slots, pulse reset low for 1 ns → all stg_valid = 0 and stg_wr = 0 immediately; dec_ready = 1.
- Back-to-back ALU dependency: add r3 <- r1+r2, then add r4 <- r3+r3 → byp_a_sel = byp_b_sel = 1, no stall; third instr reading r3 → sel = 2.
- Load-use: lw r5, then add r6 <- r5+r0 → one cycle with dec_ready = 0 and a slot-1 bubble; next cycle byp_a_sel = 2, byp_b_sel = 0.
- Priority: r7 written in slots 1 and 3, decode reads r7 → sel = 1; r0 as source with a slot writing r0 → sel = 0.
- Flush during load-use: lw r5 in slot 1, decode reads r5, flush = 1 → no stall, dec_ready = 1, slot 1 next = bubble.
- PIPE_HAZARD_PERF_EN: 10 instructions with 2 load-use stalls → after drain, perf_stall_cnt = 2 and perf_retire_cnt = 10.
